// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The operands are split into NG = WIDTH/GROUP lookahead groups, and one group
// is resolved in each pipeline stage. Each stage forwards only the operand bits
// that are still unresolved. The whole pipe stalls together when a valid result
// sits at the output and downstream is not ready. Bubbles move forward only
// when the pipe advances.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle (low only while stalled)
//   a, b       operands (WIDTH bits)
//   cin        carry-in; ignored when sub=1
//   sub        0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid  result valid
//   out_ready  downstream accepts result
//   s          sum/difference (WIDTH bits)
//   cout       carry out of the MSB (in sub mode, 1 means no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       s == 0
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    logic adv;

    // A held result at the output freezes every stage, including bubbles.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Full-lookahead carries for one group. Each carry is a flat sum of
    // products, not a ripple chain. c[0] is the group carry-in.
    function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] pp,
                                                 input logic [GROUP-1:0] gg,
                                                 input logic             c0);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & pp[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= i; m++) term = term & pp[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    for (genvar k = 0; k < NG; k++) begin : g_stage
        // Operand bits still to resolve in this stage, and sum bits known after it.
        localparam int RW = WIDTH - k * GROUP;
        localparam int SW = (k + 1) * GROUP;

        logic [RW-1:0]    a_in, b_in;
        logic             c_in, v_in;
        logic [GROUP-1:0] p, g;
        logic [GROUP:0]   c;
        logic [SW-1:0]    sum_d, sum_q;
        logic             valid_q, carry_q;

        if (k == 0) begin : g_first
            assign a_in  = a;
            assign b_in  = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign v_in  = in_valid;
            assign sum_d = p ^ c[GROUP-1:0];
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign sum_d = {p ^ c[GROUP-1:0], g_stage[k-1].sum_q};
        end

        assign p = a_in[GROUP-1:0] ^ b_in[GROUP-1:0];
        assign g = a_in[GROUP-1:0] & b_in[GROUP-1:0];
        assign c = lookahead(p, g, c_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (adv) begin
                valid_q <= v_in;
                sum_q   <= sum_d;
                carry_q <= c[GROUP];
            end
        end

        if (k < NG - 1) begin : g_fwd
            logic [RW-GROUP-1:0] a_q, b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:GROUP];
                    b_q <= b_in[RW-1:GROUP];
                end
            end
        end else begin : g_last
            logic ovf_q, zero_q;

            // c[GROUP-1] of the top group is the carry into bit WIDTH-1.
            // The flags are registered so that they also read 0 straight out of reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= c[GROUP-1] ^ c[GROUP];
                    zero_q <= (sum_d == '0);
                end
            end

            assign s         = sum_q;
            assign cout      = carry_q;
            assign out_valid = valid_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid, out_ready;
    logic [15:0] s;
    logic        cout, ovf, zero;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b1;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_out = '0;

    // Reference: {s, cout, ovf, zero}
    function automatic logic [18:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                          input logic tcin, input logic tsub);
        logic [15:0] be;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        be   = tsub ? ~tb_ : tb_;
        c0   = tsub ? 1'b1 : tcin;
        full = {1'b0, ta} + {1'b0, be} + {16'h0, c0};
        low  = {1'b0, ta[14:0]} + {1'b0, be[14:0]} + {15'h0, c0};
        return {full[15:0], full[16], low[15] ^ full[16], full[15:0] == 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, then advance to next negedge.
    task automatic cycle(input logic iv, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub, input logic ordy,
                         input logic [18:0] expv, output logic acc);
        exp_t e;
        in_valid  = iv;
        a         = ta;
        b         = tb_;
        cin       = tcin;
        sub       = tsub;
        out_ready = ordy;
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, !(out_valid && !out_ready)});
        if (prev_stall)
            chk("hold", {13'h0, out_valid, s, cout, ovf, zero}, {13'h0, 1'b1, prev_out});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'h0, out_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("s", {16'h0, s}, {16'h0, e.s});
                chk("cout", {31'h0, cout}, {31'h0, e.c});
                chk("ovf", {31'h0, ovf}, {31'h0, e.o});
                chk("zero", {31'h0, zero}, {31'h0, e.z});
                if (lat_chk) chk("latency", cyc - e.cyc, 32'd4);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e.s   = expv[18:3];
            e.c   = expv[2];
            e.o   = expv[1];
            e.z   = expv[0];
            e.cyc = cyc;
            sb.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {s, cout, ovf, zero};
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tcin, input logic tsub, input logic [18:0] expv);
        logic acc;
        cycle(1'b1, ta, tb_, tcin, tsub, 1'b1, expv, acc);
    endtask

    task automatic send_rand();
        logic [15:0] ra, rb;
        logic        rc, rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 19'h0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            idle();
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
        idle();
        idle();
    endtask

    initial begin
        logic        acc;
        logic        ordy;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          sent, t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_s", {16'h0, s}, 32'h0);
        chk("rst_cout", {31'h0, cout}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_zero", {31'h0, zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);

        // Directed vectors: {s, cout, ovf, zero}
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0});
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
        send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
        send(16'h1234, 16'h0000, 1'b0, 1'b1, {16'h1234, 1'b1, 1'b0, 1'b0});
        drain();

        // Back-to-back: latency 4 on each implies consecutive in-order output
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // Backpressure with pseudo-random out_ready and a 6-cycle hold low
        lat_chk = 1'b0;
        sent = 0;
        t = 0;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        while (sent < 10 && t < 200) begin
            ordy = (t >= 4 && t < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            cycle(1'b1, ra, rb, rc, rs, ordy, model(ra, rb, rc, rs), acc);
            if (acc) begin
                sent++;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
            end
            t++;
        end
        chk("bp_sent", sent, 32'd10);
        drain();
        lat_chk = 1'b1;

        // Reset mid-flight: in-flight results must vanish
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_s", {16'h0, s}, 32'h0);
        chk("midrst_cout", {31'h0, cout}, 32'h0);
        chk("midrst_ovf", {31'h0, ovf}, 32'h0);
        chk("midrst_zero", {31'h0, zero}, 32'h0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) idle();
        send(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, the successor to our 4-bit combinational CLA. The operand is split into GROUP-bit lookahead groups, with one group resolved per pipeline stage. Full-throughput valid/ready handshake on both sides, with whole-pipe stall under backpressure. Also produces signed-overflow and zero flags for use by datapath/ALU blocks.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP and at least GROUP.
GROUP, 4, lookahead group width in bits; each group uses full-lookahead carry equations (p=a^b, g=a&b).
NG, WIDTH/GROUP (derived localparam, not overridable), number of groups, which equals the number of pipeline stages.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
cout  output  1  carry-out of MSB; in sub mode, 1 means no borrow
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
zero  output  1  s == 0

Behaviour:
- Reset (async assert, sync release): all stage valid bits=0, out_valid=0, s=0, cout=0, ovf=0, zero=0; in_ready=1 after release. Asserting reset mid-operation discards all in-flight results, and none of them appear after release.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is transferred when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - On stall, every stage register holds its value, including bubbles.
  - With no stall, all stages advance every cycle and bubbles propagate; bubbles never block acceptance.
- Stage 0 (on accept): b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. Group 0 is computed with lookahead equations. Stage 0 registers group-0 sum bits, the group-0 carry-out, the upper operand slices of a and b_eff, and the valid bit.
- Stage k (1..NG-1): computes group k from the registered carry of stage k-1. It passes lower sum bits forward unchanged and registers the carry out. Stage k also registers c_msb_in, the carry into bit WIDTH-1, needed for ovf.
- Latency: a result accepted in cycle t is presented with out_valid=1 in cycle t+NG when no stall occurs. Throughput is one result per cycle.
- Output register = last stage: s, cout, ovf=c_msb_in^cout, zero=(s==0). These are held stable while out_valid && !out_ready.
- Arithmetic: result is modulo 2^WIDTH. a, b and s are unsigned for cout and two's-complement for ovf. sub with b=0 gives s=a, cout=1.
- Ordering: results leave in acceptance order. None are dropped or duplicated under any out_ready pattern.
- Simultaneous events:
  - If the output transfers in the same cycle an input is accepted, the pipe advances normally.
  - If out_ready rises during a stall, the pipe advances in that same cycle.
- Outputs s/cout/ovf/zero are don't-care when out_valid=0. The bench must check them only on transfer.
- WIDTH==GROUP degenerates to a single registered stage with latency 1.

Test Plan:
- WIDTH=16, GROUP=4, out_ready=1: a=16'h00FF, b=16'h0001, cin=0, sub=0 -> 4 cycles later s=16'h0100, cout=0, ovf=0, zero=0.
- Carry across all groups: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1, zero=1, ovf=0. Signed overflow: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, cout=0.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) -> s=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, ovf=1, cout=1.
- Back-to-back: 8 consecutive vectors with in_valid=1 every cycle -> 8 results on 8 consecutive cycles starting at cycle t+4, in order.
- Backpressure: stream 10 random vectors while out_ready toggles pseudo-randomly (including 6 cycles held low). Required: in_ready==!(out_valid&&!out_ready) every cycle, outputs stable during stall, all 10 results correct and in order vs a reference model.
- Reset mid-flight: accept 3 vectors, assert rst_n=0 for 1 cycle before any result emerges -> out_valid=0 and all outputs 0 immediately. No stale results after release; the next vector after release emerges with latency 4.
